// File: rtl/cpu_state_regs.sv
// Architectural state bank for the accumulator CPU: PC/IR/ACC/MDR/MAR, Z/C flags,
// per-register load enables, global stall and a LIFO context stack for call/interrupt entry.
module cpu_state_regs #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 8,
   parameter int                CTX_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic [ADDR_W-1:0]                PC_next,
   input  logic                             PC_we,
   input  logic [DATA_W-1:0]                IR_next,
   input  logic                             IR_we,
   input  logic [DATA_W-1:0]                ACC_next,
   input  logic                             ACC_we,
   input  logic [DATA_W-1:0]                MDR_next,
   input  logic                             MDR_we,
   input  logic [ADDR_W-1:0]                MAR_next,
   input  logic                             MAR_we,
   input  logic                             Zflag_next,
   input  logic                             Cflag_next,
   input  logic                             flags_we,
   input  logic                             ctx_push,
   input  logic                             ctx_pop,
   input  logic                             err_clr,
   output logic [ADDR_W-1:0]                PC_reg,
   output logic [ADDR_W-1:0]                MAR_reg,
   output logic [DATA_W-1:0]                IR_reg,
   output logic [DATA_W-1:0]                ACC_reg,
   output logic [DATA_W-1:0]                MDR_reg,
   output logic                             Zflag_reg,
   output logic                             Cflag_reg,
   output logic [$clog2(CTX_DEPTH+1)-1:0]   ctx_depth,
   output logic                             ctx_empty,
   output logic                             ctx_full,
   output logic                             ctx_overflow,
   output logic                             ctx_underflow
);
   localparam int DEPTH_W = $clog2(CTX_DEPTH + 1);
   localparam int IDX_W   = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
   localparam int ENTRY_W = ADDR_W + DATA_W + 2;

   logic [ADDR_W-1:0]  r_pc, r_mar;
   logic [DATA_W-1:0]  r_ir, r_acc, r_mdr;
   logic               r_z, r_c;
   logic [DEPTH_W-1:0] r_depth;
   logic               r_empty, r_full, r_ovf, r_unf;
   // Sized to a power of two so the index width matches exactly; extra slots are never addressed
   logic [ENTRY_W-1:0] r_stack [2**IDX_W];

   logic               w_do_push, w_do_pop, w_do_swap, w_restore, w_stack_we;
   logic               w_ovf_evt, w_unf_evt;
   logic [IDX_W-1:0]   w_top_idx, w_wr_idx;
   logic [ENTRY_W-1:0] w_cur, w_top;
   logic [DEPTH_W-1:0] w_depth_next;

   assign w_do_push  = ~stall & ctx_push & ~ctx_pop & ~r_full;
   assign w_do_pop   = ~stall & ctx_pop & ~ctx_push & ~r_empty;
   assign w_do_swap  = ~stall & ctx_push & ctx_pop & ~r_empty;
   assign w_ovf_evt  = ~stall & ctx_push & ~ctx_pop & r_full;
   assign w_unf_evt  = ~stall & ctx_pop & r_empty;
   assign w_restore  = w_do_pop | w_do_swap;
   assign w_stack_we = ~rst & (w_do_push | w_do_swap);

   assign w_top_idx = IDX_W'(r_depth - 1'b1);
   assign w_wr_idx  = w_do_swap ? w_top_idx : IDX_W'(r_depth);
   assign w_cur     = {r_pc, r_acc, r_z, r_c};
   assign w_top     = r_stack[w_top_idx];

   always_comb begin
      w_depth_next = r_depth;
      if (w_do_push)
         w_depth_next = r_depth + 1'b1;
      else if (w_do_pop)
         w_depth_next = r_depth - 1'b1;
   end

   // Stack contents are deliberately not reset; only the depth pointer is
   always_ff @(posedge clk) begin
      if (w_stack_we)
         r_stack[w_wr_idx] <= w_cur;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_ir    <= '0;
         r_acc   <= '0;
         r_mdr   <= '0;
         r_mar   <= '0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
         r_depth <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_ovf <= w_ovf_evt | (r_ovf & ~err_clr);
         r_unf <= w_unf_evt | (r_unf & ~err_clr);
         if (!stall) begin
            if (w_restore) begin
               {r_pc, r_acc, r_z, r_c} <= w_top;
            end else begin
               if (PC_we)    r_pc  <= PC_next;
               if (ACC_we)   r_acc <= ACC_next;
               if (flags_we) begin
                  r_z <= Zflag_next;
                  r_c <= Cflag_next;
               end
            end
            if (IR_we)  r_ir  <= IR_next;
            if (MDR_we) r_mdr <= MDR_next;
            if (MAR_we) r_mar <= MAR_next;
            r_depth <= w_depth_next;
            r_empty <= (w_depth_next == '0);
            r_full  <= (w_depth_next == DEPTH_W'(CTX_DEPTH));
         end
      end
   end

   assign PC_reg        = r_pc;
   assign MAR_reg       = r_mar;
   assign IR_reg        = r_ir;
   assign ACC_reg       = r_acc;
   assign MDR_reg       = r_mdr;
   assign Zflag_reg     = r_z;
   assign Cflag_reg     = r_c;
   assign ctx_depth     = r_depth;
   assign ctx_empty     = r_empty;
   assign ctx_full      = r_full;
   assign ctx_overflow  = r_ovf;
   assign ctx_underflow = r_unf;
endmodule

// File: tb/tb_cpu_state_regs.sv
// Bench for cpu_state_regs: directed scenarios plus randomized traffic against a
// queue-based architectural model of the register bank and context stack.
module tb_cpu_state_regs;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int CTX_DEPTH = 4;
   localparam logic [7:0] RST_PC = 8'h10;

   logic clk = 1'b0;
   logic rst, stall, PC_we, IR_we, ACC_we, MDR_we, MAR_we;
   logic Zflag_next, Cflag_next, flags_we, ctx_push, ctx_pop, err_clr;
   logic [ADDR_W-1:0] PC_next, MAR_next, PC_reg, MAR_reg;
   logic [DATA_W-1:0] IR_next, ACC_next, MDR_next, IR_reg, ACC_reg, MDR_reg;
   logic Zflag_reg, Cflag_reg, ctx_empty, ctx_full, ctx_overflow, ctx_underflow;
   logic [2:0] ctx_depth;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] acc;
      logic        z;
      logic        c;
   } ctx_t;

   ctx_t        m_stack[$];
   logic [7:0]  m_pc, m_mar;
   logic [15:0] m_ir, m_acc, m_mdr;
   logic        m_z, m_c, m_ovf, m_unf;

   always #5 clk = ~clk;

   cpu_state_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTX_DEPTH(CTX_DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .PC_next(PC_next), .PC_we(PC_we), .IR_next(IR_next), .IR_we(IR_we),
      .ACC_next(ACC_next), .ACC_we(ACC_we), .MDR_next(MDR_next), .MDR_we(MDR_we),
      .MAR_next(MAR_next), .MAR_we(MAR_we), .Zflag_next(Zflag_next), .Cflag_next(Cflag_next),
      .flags_we(flags_we), .ctx_push(ctx_push), .ctx_pop(ctx_pop), .err_clr(err_clr),
      .PC_reg(PC_reg), .MAR_reg(MAR_reg), .IR_reg(IR_reg), .ACC_reg(ACC_reg), .MDR_reg(MDR_reg),
      .Zflag_reg(Zflag_reg), .Cflag_reg(Cflag_reg), .ctx_depth(ctx_depth),
      .ctx_empty(ctx_empty), .ctx_full(ctx_full),
      .ctx_overflow(ctx_overflow), .ctx_underflow(ctx_underflow)
   );

   // Architectural model: applies the documented rules to the inputs seen at the edge
   task automatic model_step();
      ctx_t cur, top;
      logic ovf_evt, unf_evt;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (rst) begin
         m_pc = RST_PC; m_ir = '0; m_acc = '0; m_mdr = '0; m_mar = '0;
         m_z = 1'b0; m_c = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         m_stack.delete();
         return;
      end
      if (!stall) begin
         cur = '{pc: m_pc, acc: m_acc, z: m_z, c: m_c};
         if (PC_we)    m_pc = PC_next;
         if (ACC_we)   m_acc = ACC_next;
         if (flags_we) begin m_z = Zflag_next; m_c = Cflag_next; end
         if (IR_we)    m_ir = IR_next;
         if (MDR_we)   m_mdr = MDR_next;
         if (MAR_we)   m_mar = MAR_next;
         if (ctx_pop) begin
            if (m_stack.size() == 0) begin
               unf_evt = 1'b1;
            end else begin
               top = m_stack.pop_back();
               if (ctx_push) m_stack.push_back(cur);
               m_pc = top.pc; m_acc = top.acc; m_z = top.z; m_c = top.c;
            end
         end else if (ctx_push) begin
            if (m_stack.size() == CTX_DEPTH) ovf_evt = 1'b1;
            else m_stack.push_back(cur);
         end
      end
      m_ovf = ovf_evt | (m_ovf & ~err_clr);
      m_unf = unf_evt | (m_unf & ~err_clr);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; stall = 0; PC_we = 0; IR_we = 0; ACC_we = 0; MDR_we = 0; MAR_we = 0;
      flags_we = 0; ctx_push = 0; ctx_pop = 0; err_clr = 0;
      PC_next = '0; IR_next = '0; ACC_next = '0; MDR_next = '0; MAR_next = '0;
      Zflag_next = 0; Cflag_next = 0;
   endtask

   task automatic randomize_inputs();
      stall = 1'($urandom); PC_we = 1'($urandom); IR_we = 1'($urandom); ACC_we = 1'($urandom);
      MDR_we = 1'($urandom); MAR_we = 1'($urandom); flags_we = 1'($urandom);
      ctx_push = 1'($urandom); ctx_pop = 1'($urandom); err_clr = 1'($urandom);
      PC_next = 8'($urandom); IR_next = 16'($urandom); ACC_next = 16'($urandom);
      MDR_next = 16'($urandom); MAR_next = 8'($urandom);
      Zflag_next = 1'($urandom); Cflag_next = 1'($urandom);
   endtask

   task automatic test_reset();
      randomize_inputs();
      rst = 1;
      cycle();
      checks++;
      if ({PC_reg, ACC_reg, IR_reg, MDR_reg, MAR_reg, Zflag_reg, Cflag_reg} !== {8'h10, 16'h0, 16'h0, 16'h0, 8'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset_regs: PC=%h ACC=%h IR=%h MDR=%h MAR=%h Z=%b C=%b, expected PC=10 rest 0",
                  PC_reg, ACC_reg, IR_reg, MDR_reg, MAR_reg, Zflag_reg, Cflag_reg);
      end
      checks++;
      if ({ctx_depth, ctx_empty, ctx_full, ctx_overflow, ctx_underflow} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ctx: depth=%0d empty=%b full=%b ovf=%b unf=%b, expected 0 1 0 0 0",
                  ctx_depth, ctx_empty, ctx_full, ctx_overflow, ctx_underflow);
      end
      $display("reset: PC=%h depth=%0d empty=%b", PC_reg, ctx_depth, ctx_empty);
      idle_inputs();
   endtask

   task automatic test_selective_write();
      ACC_we = 1; ACC_next = 16'hBEEF;
      cycle();
      checks++;
      if (ACC_reg !== 16'hBEEF || PC_reg !== 8'h10) begin
         errors++;
         $display("FAIL sel_write: ACC=%h PC=%h, expected ACC=beef PC=10", ACC_reg, PC_reg);
      end
      $display("sel_write: ACC=%h PC=%h", ACC_reg, PC_reg);
      randomize_inputs();
      stall = 1; ctx_push = 1; ctx_pop = 0; err_clr = 0;
      ACC_we = 1; PC_we = 1; IR_we = 1;
      cycle();
      checks++;
      if (ACC_reg !== 16'hBEEF || PC_reg !== 8'h10 || IR_reg !== 16'h0 || ctx_depth !== 3'd0 || ctx_overflow !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: ACC=%h PC=%h IR=%h depth=%0d ovf=%b, expected beef 10 0000 0 0",
                  ACC_reg, PC_reg, IR_reg, ctx_depth, ctx_overflow);
      end
      $display("stall: ACC=%h PC=%h depth=%0d", ACC_reg, PC_reg, ctx_depth);
      idle_inputs();
   endtask

   task automatic test_interrupt();
      PC_we = 1; PC_next = 8'h22; ACC_we = 1; ACC_next = 16'h1234;
      flags_we = 1; Zflag_next = 1; Cflag_next = 0;
      cycle();
      idle_inputs();
      ctx_push = 1; PC_we = 1; PC_next = 8'h80;
      cycle();
      checks++;
      if (PC_reg !== 8'h80 || ctx_depth !== 3'd1 || ctx_empty !== 1'b0) begin
         errors++;
         $display("FAIL irq_entry: PC=%h depth=%0d empty=%b, expected 80 1 0", PC_reg, ctx_depth, ctx_empty);
      end
      $display("irq_entry: PC=%h depth=%0d", PC_reg, ctx_depth);
      idle_inputs();
      ACC_we = 1; ACC_next = 16'h5555; flags_we = 1; Zflag_next = 0; Cflag_next = 1;
      cycle();
      idle_inputs();
      ctx_pop = 1; PC_we = 1; PC_next = 8'h99; ACC_we = 1; ACC_next = 16'h7777; IR_we = 1; IR_next = 16'hABCD;
      cycle();
      checks++;
      if (PC_reg !== 8'h22 || ACC_reg !== 16'h1234 || Zflag_reg !== 1'b1 || Cflag_reg !== 1'b0 ||
          IR_reg !== 16'hABCD || ctx_depth !== 3'd0 || ctx_empty !== 1'b1) begin
         errors++;
         $display("FAIL irq_return: PC=%h ACC=%h Z=%b C=%b IR=%h depth=%0d, expected 22 1234 1 0 abcd 0",
                  PC_reg, ACC_reg, Zflag_reg, Cflag_reg, IR_reg, ctx_depth);
      end
      $display("irq_return: PC=%h ACC=%h Z=%b depth=%0d", PC_reg, ACC_reg, Zflag_reg, ctx_depth);
      idle_inputs();
   endtask

   task automatic test_overflow();
      PC_we = 1; PC_next = 8'h30;
      cycle();
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         ctx_push = 1; PC_we = 1; PC_next = 8'(8'h31 + i);
         cycle();
         checks++;
         if (PC_reg !== 8'(8'h31 + i) || ctx_depth !== 3'((i < 4) ? i + 1 : 4) ||
             ctx_overflow !== (i == 4) || ctx_full !== (i >= 3)) begin
            errors++;
            $display("FAIL fill_%0d: PC=%h depth=%0d full=%b ovf=%b, expected %h %0d %b %b", i, PC_reg,
                     ctx_depth, ctx_full, ctx_overflow, 8'(8'h31 + i), (i < 4) ? i + 1 : 4, i >= 3, i == 4);
         end
         $display("push %0d: PC=%h depth=%0d full=%b ovf=%b", i, PC_reg, ctx_depth, ctx_full, ctx_overflow);
      end
      idle_inputs();
      err_clr = 1;
      cycle();
      checks++;
      if (ctx_overflow !== 1'b0 || ctx_depth !== 3'd4) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b depth=%0d, expected 0 4", ctx_overflow, ctx_depth);
      end
      $display("err_clr: ovf=%b depth=%0d", ctx_overflow, ctx_depth);
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         ctx_pop = 1;
         cycle();
         checks++;
         if (PC_reg !== 8'(8'h33 - i) || ctx_depth !== 3'(3 - i)) begin
            errors++;
            $display("FAIL lifo_%0d: PC=%h depth=%0d, expected %h %0d", i, PC_reg, ctx_depth, 8'(8'h33 - i), 3 - i);
         end
         $display("pop %0d: PC=%h depth=%0d", i, PC_reg, ctx_depth);
      end
      idle_inputs();
   endtask

   task automatic test_underflow();
      ctx_pop = 1; PC_we = 1; PC_next = 8'h77;
      cycle();
      checks++;
      if (ctx_underflow !== 1'b1 || PC_reg !== 8'h77 || ctx_depth !== 3'd0) begin
         errors++;
         $display("FAIL underflow_pop: unf=%b PC=%h depth=%0d, expected 1 77 0", ctx_underflow, PC_reg, ctx_depth);
      end
      $display("pop empty: unf=%b PC=%h", ctx_underflow, PC_reg);
      idle_inputs();
      err_clr = 1;
      cycle();
      idle_inputs();
      ctx_pop = 1; ctx_push = 1; PC_we = 1; PC_next = 8'h78;
      cycle();
      checks++;
      if (ctx_underflow !== 1'b1 || PC_reg !== 8'h78 || ctx_depth !== 3'd0) begin
         errors++;
         $display("FAIL underflow_swap: unf=%b PC=%h depth=%0d, expected 1 78 0", ctx_underflow, PC_reg, ctx_depth);
      end
      $display("swap empty: unf=%b PC=%h", ctx_underflow, PC_reg);
      idle_inputs();
      err_clr = 1; ctx_pop = 1;
      cycle();
      checks++;
      if (ctx_underflow !== 1'b1) begin
         errors++;
         $display("FAIL err_clr_race: unf=%b, expected 1", ctx_underflow);
      end
      idle_inputs();
      err_clr = 1; stall = 1;
      cycle();
      checks++;
      if (ctx_underflow !== 1'b0) begin
         errors++;
         $display("FAIL err_clr_stall: unf=%b, expected 0", ctx_underflow);
      end
      $display("err_clr under stall: unf=%b", ctx_underflow);
      idle_inputs();
   endtask

   task automatic test_swap();
      PC_we = 1; PC_next = 8'h40;
      cycle();
      idle_inputs();
      ctx_push = 1; PC_we = 1; PC_next = 8'h55;
      cycle();
      idle_inputs();
      ctx_push = 1; ctx_pop = 1;
      cycle();
      checks++;
      if (PC_reg !== 8'h40 || ctx_depth !== 3'd1) begin
         errors++;
         $display("FAIL swap: PC=%h depth=%0d, expected 40 1", PC_reg, ctx_depth);
      end
      $display("swap: PC=%h depth=%0d", PC_reg, ctx_depth);
      idle_inputs();
      ctx_pop = 1;
      cycle();
      checks++;
      if (PC_reg !== 8'h55 || ctx_depth !== 3'd0) begin
         errors++;
         $display("FAIL swap_pop: PC=%h depth=%0d, expected 55 0", PC_reg, ctx_depth);
      end
      $display("pop after swap: PC=%h depth=%0d", PC_reg, ctx_depth);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      ACC_we = 1; ACC_next = 16'hC0DE; PC_we = 1; PC_next = 8'h61;
      cycle();
      idle_inputs();
      ctx_push = 1; ACC_we = 1; ACC_next = 16'h0000; PC_we = 1; PC_next = 8'h62;
      cycle();
      idle_inputs();
      ctx_pop = 1;
      cycle();
      checks++;
      if (PC_reg !== 8'h61 || ACC_reg !== 16'hC0DE || ctx_depth !== 3'd0) begin
         errors++;
         $display("FAIL back_to_back: PC=%h ACC=%h depth=%0d, expected 61 c0de 0", PC_reg, ACC_reg, ctx_depth);
      end
      $display("back_to_back: PC=%h ACC=%h", PC_reg, ACC_reg);
      idle_inputs();
   endtask

   task automatic test_random();
      int bad;
      for (int n = 0; n < 3000; n++) begin
         randomize_inputs();
         stall = ($urandom_range(0, 7) == 0);
         err_clr = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 199) == 0);
         cycle();
         bad = 0;
         checks++;
         if ({PC_reg, ACC_reg, IR_reg, MDR_reg, MAR_reg, Zflag_reg, Cflag_reg} !==
             {m_pc, m_acc, m_ir, m_mdr, m_mar, m_z, m_c}) begin
            errors++; bad = 1;
            $display("FAIL rand_regs[%0d]: PC=%h ACC=%h IR=%h MDR=%h MAR=%h ZC=%b%b, expected %h %h %h %h %h %b%b",
                     n, PC_reg, ACC_reg, IR_reg, MDR_reg, MAR_reg, Zflag_reg, Cflag_reg,
                     m_pc, m_acc, m_ir, m_mdr, m_mar, m_z, m_c);
         end
         checks++;
         if ({ctx_depth, ctx_empty, ctx_full, ctx_overflow, ctx_underflow} !==
             {3'(m_stack.size()), m_stack.size() == 0, m_stack.size() == CTX_DEPTH, m_ovf, m_unf}) begin
            errors++; bad = 1;
            $display("FAIL rand_ctx[%0d]: depth=%0d empty=%b full=%b ovf=%b unf=%b, expected %0d ovf=%b unf=%b",
                     n, ctx_depth, ctx_empty, ctx_full, ctx_overflow, ctx_underflow, m_stack.size(), m_ovf, m_unf);
         end
         if (n % 250 == 0 || bad != 0)
            $display("rand %0d: PC=%h ACC=%h depth=%0d ovf=%b unf=%b", n, PC_reg, ACC_reg, ctx_depth,
                     ctx_overflow, ctx_underflow);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      m_pc = '0; m_ir = '0; m_acc = '0; m_mdr = '0; m_mar = '0;
      m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
      #2;
      test_reset();
      test_selective_write();
      test_interrupt();
      test_overflow();
      test_underflow();
      test_swap();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
